mem_or_io_unit: RTL and testbench
=================================

Name: mem_or_io_unit

Overview:
- Data-side counterpart of the register-file decoder. It produces the 32-bit read_data the decoder writes back on loads, and it sinks the store data the decoder supplies from read_data_2.
- Routes each load/store either to the data RAM or to memory-mapped I/O: LEDs, switches and an 8-digit 7-segment display.
- Owns the I/O registers, the switch synchronizer/debouncer and the display scan logic.
- Sits between the executer (address), the decoder (store data, load result) and the board pins.

Parameters:
- DEBOUNCE_CYCLES, 20'd1000000: cycles the synchronized switch value must stay stable before it is accepted.
- SCAN_DIV, 17'd100000: clk cycles per displayed digit.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- addr_in  in  32  byte address from the executer ALU_result
- mem_read  in  1  load from data RAM
- mem_write  in  1  store to data RAM
- io_read  in  1  load from I/O space
- io_write  in  1  store to I/O space
- m_rdata  in  32  read data returned by the data RAM
- r_wdata  in  32  store data, taken from decoder read_data_2
- r_rdata  out  32  load result to the decoder read_data input
- address  out  32  address to the data RAM; equals addr_in
- m_wdata  out  32  write data to the data RAM; equals r_wdata
- mem_we  out  1  data RAM write enable
- switch_in  in  24  raw board switches, asynchronous
- led_out  out  24  LED drive, 1 = on
- seg_out  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- seg_an  out  8  digit anodes, active-low; bit i selects digit i

Behaviour:
- Reset: the clock port is clk and the reset port is rst; reset is synchronous and active-high, as already decided. While rst is high at a clock edge, all of the following are cleared:
  - led_out = 0, seg_value = 0, seg_mask = 0, switch debounced value = 0.
  - Synchronizer flops = 0, debounce counter = 0, scan counter = 0, digit index = 0.
  - Consequence: seg_an = 8'hFF and seg_out = 8'hFF (all dark).
- I/O map (full 32-bit compare; anything else in I/O space is unmapped):
  - 0xFFFFFC60: LED register, R/W, low 24 bits.
  - 0xFFFFFC70: switches, read-only.
  - 0xFFFFFC80: seg_value, R/W, 32 bits, 8 hex digits; digit 0 = bits [3:0].
  - 0xFFFFFC84: seg_mask, R/W, low 8 bits; bit i = 1 enables digit i.
- Loads (combinational, zero latency; the RAM read latency itself is outside this block):
  - mem_read=1 -> r_rdata = m_rdata.
  - io_read=1 at 0xFFFFFC60 -> {8'b0, led_out}.
  - io_read=1 at 0xFFFFFC70 -> {8'b0, sw_db}.
  - io_read=1 at 0xFFFFFC80 -> seg_value.
  - io_read=1 at 0xFFFFFC84 -> {24'b0, seg_mask}.
  - io_read=1 at an unmapped address -> 0.
  - No read strobe -> 0.
  - mem_read and io_read both high: io_read wins.
- Stores:
  - mem_we = mem_write & ~io_write; this suppresses a RAM write on the illegal simultaneous case.
  - io_write=1 at a mapped writable address updates that register from r_wdata at the next edge. The new value is visible on led_out and on read-back from the following cycle.
  - Writes to 0xFFFFFC70 or to unmapped addresses are ignored.
  - rst and io_write in the same cycle: reset wins.
- Switch path:
  - 2-flop synchronizer produces sw_sync.
  - If sw_sync differs from sw_db: the counter increments. When counter == DEBOUNCE_CYCLES-1, sw_db <= sw_sync and the counter clears.
  - If sw_sync equals sw_db: the counter clears.
  - Any bounce back to the sw_db value restarts the count from 0.
- Display scan:
  - The scan counter counts 0..SCAN_DIV-1 and wraps. On the wrap, the digit index increments, wrapping 7 -> 0.
  - seg_an = ~(onehot(index) & seg_mask). A digit whose mask bit is 0 stays dark (anode high).
  - seg_out = the active-low hex pattern of nibble[index] with dp = 1 (off), registered. Examples: 0 = 8'hC0, 1 = 8'hF9, 8 = 8'h80, A = 8'h88, F = 8'h8E.
  - Writing seg_value mid-scan takes effect on the next registered seg_out update; there is no glitch on seg_an.

Test Plan:
- Reset, then hold rst=1 for 2 cycles -> led_out=0, seg_an=8'hFF, seg_out=8'hFF. io_read at 0xFFFFFC60 -> r_rdata=0.
- io_write=1, addr 0xFFFFFC60, r_wdata=0xDEADBEEF -> next cycle led_out=24'hADBEEF, read-back=0x00ADBEEF. mem_we stays 0 throughout.
- mem_write=1, addr 0x00000010, r_wdata=0x12345678 -> mem_we=1, m_wdata=0x12345678, address=0x10. Then mem_read with m_rdata=0xCAFEF00D -> r_rdata=0xCAFEF00D in the same cycle.
- With DEBOUNCE_CYCLES=4:
  - switch_in=24'h00000F held -> sw_db updates exactly 2+4 cycles after the change; read at 0xFFFFFC70 returns 0x0000000F.
  - A 2-cycle glitch to 24'h000000 -> no change to sw_db.
- With SCAN_DIV=2: seg_value=0x0000001A, seg_mask=8'h03 -> over 16 cycles:
  - index 0: seg_an=8'hFE, seg_out=8'h88.
  - index 1: seg_an=8'hFD, seg_out=8'hF9.
  - indices 2-7: seg_an=8'hFF.
- io_write at unmapped 0xFFFFFC90, then io_read there -> r_rdata=0, no register changes. io_write together with mem_write -> mem_we=0.

Source files
------------

// File: rtl/mem_or_io_unit.sv
// Data-side load/store router: data RAM versus memory-mapped LEDs, switches and
// an 8-digit 7-segment display, including switch debounce and display scanning.
module mem_or_io_unit #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
    parameter logic [16:0] SCAN_DIV        = 17'd100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [31:0] m_rdata,
    input  logic [31:0] r_wdata,
    output logic [31:0] r_rdata,
    output logic [31:0] address,
    output logic [31:0] m_wdata,
    output logic        mem_we,
    input  logic [23:0] switch_in,
    output logic [23:0] led_out,
    output logic [7:0]  seg_out,
    output logic [7:0]  seg_an
);

    localparam logic [31:0] ADDR_LED  = 32'hFFFF_FC60;
    localparam logic [31:0] ADDR_SW   = 32'hFFFF_FC70;
    localparam logic [31:0] ADDR_SEGV = 32'hFFFF_FC80;
    localparam logic [31:0] ADDR_SEGM = 32'hFFFF_FC84;

    logic [31:0] seg_value;
    logic [7:0]  seg_mask;
    logic [23:0] sw_meta;
    logic [23:0] sw_sync;
    logic [23:0] sw_db;
    logic [19:0] db_cnt;
    logic [16:0] scan_cnt;
    logic [2:0]  digit_idx;
    logic [2:0]  idx_next;
    logic        scan_wrap;
    logic [3:0]  nibble;
    logic [7:0]  seg_pat;

    assign address = addr_in;
    assign m_wdata = r_wdata;
    assign mem_we  = mem_write & ~io_write;

    always_comb begin
        r_rdata = 32'd0;
        if (io_read) begin
            case (addr_in)
                ADDR_LED:  r_rdata = {8'd0, led_out};
                ADDR_SW:   r_rdata = {8'd0, sw_db};
                ADDR_SEGV: r_rdata = seg_value;
                ADDR_SEGM: r_rdata = {24'd0, seg_mask};
                default:   r_rdata = 32'd0;
            endcase
        end else if (mem_read) begin
            r_rdata = m_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_out   <= 24'd0;
            seg_value <= 32'd0;
            seg_mask  <= 8'd0;
        end else if (io_write) begin
            case (addr_in)
                ADDR_LED:  led_out   <= r_wdata[23:0];
                ADDR_SEGV: seg_value <= r_wdata;
                ADDR_SEGM: seg_mask  <= r_wdata[7:0];
                default:   ;
            endcase
        end
    end

    // Any return of sw_sync to the accepted value restarts the stability count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= 24'd0;
            sw_sync <= 24'd0;
            sw_db   <= 24'd0;
            db_cnt  <= 20'd0;
        end else begin
            sw_meta <= switch_in;
            sw_sync <= sw_meta;
            if (sw_sync != sw_db) begin
                if (db_cnt == DEBOUNCE_CYCLES - 20'd1) begin
                    sw_db  <= sw_sync;
                    db_cnt <= 20'd0;
                end else begin
                    db_cnt <= db_cnt + 20'd1;
                end
            end else begin
                db_cnt <= 20'd0;
            end
        end
    end

    assign scan_wrap = (scan_cnt == SCAN_DIV - 17'd1);
    assign idx_next  = scan_wrap ? digit_idx + 3'd1 : digit_idx;
    assign nibble    = seg_value[{idx_next, 2'b00} +: 4];

    always_comb begin
        case (nibble)
            4'h0:    seg_pat = 8'hC0;
            4'h1:    seg_pat = 8'hF9;
            4'h2:    seg_pat = 8'hA4;
            4'h3:    seg_pat = 8'hB0;
            4'h4:    seg_pat = 8'h99;
            4'h5:    seg_pat = 8'h92;
            4'h6:    seg_pat = 8'h82;
            4'h7:    seg_pat = 8'hF8;
            4'h8:    seg_pat = 8'h80;
            4'h9:    seg_pat = 8'h90;
            4'hA:    seg_pat = 8'h88;
            4'hB:    seg_pat = 8'h83;
            4'hC:    seg_pat = 8'hC6;
            4'hD:    seg_pat = 8'hA1;
            4'hE:    seg_pat = 8'h86;
            default: seg_pat = 8'h8E;
        endcase
    end

    // Anodes and segments are both registered from idx_next so they switch on the
    // same edge and the anode drive cannot glitch through decode logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= 17'd0;
            digit_idx <= 3'd0;
            seg_out   <= 8'hFF;
            seg_an    <= 8'hFF;
        end else begin
            scan_cnt  <= scan_wrap ? 17'd0 : scan_cnt + 17'd1;
            digit_idx <= idx_next;
            seg_out   <= seg_pat;
            seg_an    <= ~((8'd1 << idx_next) & seg_mask);
        end
    end

endmodule

// File: tb/tb_mem_or_io_unit.sv
// Directed bench for mem_or_io_unit with short debounce and scan periods.
module tb_mem_or_io_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_in;
    logic        mem_read, mem_write, io_read, io_write;
    logic [31:0] m_rdata, r_wdata, r_rdata, address, m_wdata;
    logic        mem_we;
    logic [23:0] switch_in, led_out;
    logic [7:0]  seg_out, seg_an;

    int total  = 0;
    int passed = 0;

    mem_or_io_unit #(.DEBOUNCE_CYCLES(20'd4), .SCAN_DIV(17'd2)) dut (
        .clk(clk), .rst(rst), .addr_in(addr_in),
        .mem_read(mem_read), .mem_write(mem_write),
        .io_read(io_read), .io_write(io_write),
        .m_rdata(m_rdata), .r_wdata(r_wdata), .r_rdata(r_rdata),
        .address(address), .m_wdata(m_wdata), .mem_we(mem_we),
        .switch_in(switch_in), .led_out(led_out),
        .seg_out(seg_out), .seg_an(seg_an)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic rd_io(input logic [31:0] a, input string tag, input logic [31:0] exp);
        io_read = 1'b1;
        addr_in = a;
        #1;
        check(tag, r_rdata, exp);
        io_read = 1'b0;
    endtask

    initial begin
        int n_fe, n_fd, n_ff;
        rst = 1'b1; addr_in = 32'd0; mem_read = 1'b0; mem_write = 1'b0;
        io_read = 1'b0; io_write = 1'b0; m_rdata = 32'd0; r_wdata = 32'd0;
        switch_in = 24'd0;
        tick(); tick();
        check("rst_led", {8'd0, led_out}, 32'd0);
        check("rst_an", {24'd0, seg_an}, 32'hFF);
        check("rst_seg", {24'd0, seg_out}, 32'hFF);
        rd_io(32'hFFFF_FC60, "rst_led_rd", 32'd0);
        rst = 1'b0;

        // LED write and read-back
        io_write = 1'b1; addr_in = 32'hFFFF_FC60; r_wdata = 32'hDEAD_BEEF;
        #1 check("io_wr_we", {31'd0, mem_we}, 32'd0);
        tick();
        io_write = 1'b0;
        check("led_val", {8'd0, led_out}, 32'h00AD_BEEF);
        rd_io(32'hFFFF_FC60, "led_rd", 32'h00AD_BEEF);
        check("led_rd_we", {31'd0, mem_we}, 32'd0);

        // RAM path
        mem_write = 1'b1; addr_in = 32'h10; r_wdata = 32'h1234_5678;
        #1;
        check("mem_we", {31'd0, mem_we}, 32'd1);
        check("m_wdata", m_wdata, 32'h1234_5678);
        check("address", address, 32'h10);
        mem_write = 1'b0; mem_read = 1'b1; m_rdata = 32'hCAFE_F00D;
        #1 check("mem_rd", r_rdata, 32'hCAFE_F00D);
        rd_io(32'hFFFF_FC60, "io_wins", 32'h00AD_BEEF);
        mem_read = 1'b0;
        #1 check("no_strobe", r_rdata, 32'd0);

        // Debounce: sw_db accepts the new value exactly 6 edges after the change
        switch_in = 24'h00000F;
        repeat (5) tick();
        rd_io(32'hFFFF_FC70, "sw_early", 32'd0);
        tick();
        rd_io(32'hFFFF_FC70, "sw_accept", 32'h0000_000F);

        // Two-cycle glitch is rejected
        switch_in = 24'h000000;
        tick(); tick();
        switch_in = 24'h00000F;
        repeat (10) tick();
        rd_io(32'hFFFF_FC70, "sw_glitch", 32'h0000_000F);

        // Switch register is read-only
        io_write = 1'b1; addr_in = 32'hFFFF_FC70; r_wdata = 32'd0;
        tick();
        io_write = 1'b0;
        rd_io(32'hFFFF_FC70, "sw_ro", 32'h0000_000F);

        // Display registers and scan
        io_write = 1'b1; addr_in = 32'hFFFF_FC80; r_wdata = 32'h0000_001A;
        tick();
        addr_in = 32'hFFFF_FC84; r_wdata = 32'h0000_0003;
        tick();
        io_write = 1'b0;
        rd_io(32'hFFFF_FC80, "segv_rd", 32'h0000_001A);
        rd_io(32'hFFFF_FC84, "segm_rd", 32'h0000_0003);
        tick();
        n_fe = 0; n_fd = 0; n_ff = 0;
        for (int i = 0; i < 16; i++) begin
            if (seg_an == 8'hFE) begin
                n_fe++;
                check("dig0_seg", {24'd0, seg_out}, 32'h88);
            end else if (seg_an == 8'hFD) begin
                n_fd++;
                check("dig1_seg", {24'd0, seg_out}, 32'hF9);
            end else begin
                n_ff++;
                check("dark_an", {24'd0, seg_an}, 32'hFF);
            end
            tick();
        end
        check("cnt_dig0", n_fe, 32'd2);
        check("cnt_dig1", n_fd, 32'd2);
        check("cnt_dark", n_ff, 32'd12);

        // Unmapped write alongside an illegal RAM write
        io_write = 1'b1; mem_write = 1'b1; addr_in = 32'hFFFF_FC90; r_wdata = 32'hFFFF_FFFF;
        #1 check("both_we", {31'd0, mem_we}, 32'd0);
        tick();
        io_write = 1'b0; mem_write = 1'b0;
        rd_io(32'hFFFF_FC90, "unmap_rd", 32'd0);
        rd_io(32'hFFFF_FC60, "unmap_led", 32'h00AD_BEEF);
        rd_io(32'hFFFF_FC80, "unmap_segv", 32'h0000_001A);
        rd_io(32'hFFFF_FC84, "unmap_segm", 32'h0000_0003);

        // Reset beats a simultaneous I/O write
        rst = 1'b1; io_write = 1'b1; addr_in = 32'hFFFF_FC60; r_wdata = 32'h0012_3456;
        tick();
        rst = 1'b0; io_write = 1'b0;
        check("rst_wr_led", {8'd0, led_out}, 32'd0);
        check("rst_wr_an", {24'd0, seg_an}, 32'hFF);
        check("rst_wr_seg", {24'd0, seg_out}, 32'hFF);
        rd_io(32'hFFFF_FC70, "rst_sw", 32'd0);
        rd_io(32'hFFFF_FC80, "rst_segv", 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
